// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - slot-aligned N-port arbiter for the shared SDRAM controller
// Fixed-priority or round-robin grant with per-port lock; one access per granted slot.
module sdram_port_arbiter #(
  parameter int NPORTS      = 3,
  parameter int AW          = 25,
  parameter int DW          = 8,
  parameter int RR_MODE     = 0,
  parameter int SLOT_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 res_n_i,
  input  logic                 slot_start,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS-1:0]    lock,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        dout,
  output logic [2:0]           grant_idx,
  output logic                 busy,
  output logic [AW-1:0]        sd_addr,
  output logic [DW-1:0]        sd_din,
  output logic                 sd_we,
  output logic                 sd_oe,
  input  logic [DW-1:0]        sd_dout
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   lock_owner;
  logic            lock_valid;
  logic [PW-1:0]   grant_r;
  logic [PW-1:0]   win;
  logic            found;
  logic            start;
  logic            done;

  // Winner selection: a live lock owner first, then the configured policy.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (lock_valid && req[lock_owner]) begin
      win   = lock_owner;
      found = 1'b1;
    end else if (RR_MODE != 0 && NPORTS > 1) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!found && req[(int'(ptr) + i) % NPORTS]) begin
          win   = PW'((int'(ptr) + i) % NPORTS);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!found && req[i]) begin
          win   = PW'(i);
          found = 1'b1;
        end
      end
    end
  end

  // busy stays high through the ack cycle, which keeps a coincident slot from arbitrating.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        start = !busy && slot_start && (|req);
        if (start) state_next = ACCESS;
      end
      ACCESS: begin
        done = (cnt == CW'(SLOT_CYCLES - 1));
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      lock_owner <= '0;
      lock_valid <= 1'b0;
      grant_r    <= '0;
      ack        <= '0;
      dout       <= '0;
      busy       <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_we      <= 1'b0;
      sd_oe      <= 1'b0;
    end else begin
      state <= state_next;
      ack   <= '0;
      if (start) begin
        sd_addr <= addr[int'(win)*AW +: AW];
        sd_din  <= din[int'(win)*DW +: DW];
        sd_we   <= we[win];
        sd_oe   <= ~we[win];
        busy    <= 1'b1;
        grant_r <= win;
        cnt     <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (done) begin
          ack[grant_r] <= 1'b1;
          if (sd_oe) dout <= sd_dout;
          sd_we      <= 1'b0;
          sd_oe      <= 1'b0;
          ptr        <= (int'(grant_r) == NPORTS - 1) ? '0 : grant_r + 1'b1;
          lock_valid <= lock[grant_r];
          lock_owner <= lock[grant_r] ? grant_r : '0;
        end
      end else if (busy) begin
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    grant_idx           = '0;
    grant_idx[PW-1:0]   = grant_r;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - bench for sdram_port_arbiter, fixed and round-robin instances
module tb_sdram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 25;
  localparam int DW = 8;
  localparam int S  = 8;

  logic            clk_i = 1'b0;
  logic            res_n_i = 1'b0;
  logic            slot_start = 1'b0;
  logic [N-1:0]    req = '0, we = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] din = '0;
  logic [DW-1:0]   sd_dout = '0;

  logic [N-1:0]    ack_o [2];
  logic [DW-1:0]   dout_o [2];
  logic [2:0]      gidx_o [2];
  logic            busy_o [2];
  logic [AW-1:0]   sdaddr_o [2];
  logic [DW-1:0]   sddin_o [2];
  logic            sdwe_o [2];
  logic            sdoe_o [2];

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  sdram_port_arbiter #(.NPORTS(N), .AW(AW), .DW(DW), .RR_MODE(0), .SLOT_CYCLES(S)) d_fix (
    .clk_i(clk_i), .res_n_i(res_n_i), .slot_start(slot_start), .req(req), .we(we), .lock(lock),
    .addr(addr), .din(din), .ack(ack_o[0]), .dout(dout_o[0]), .grant_idx(gidx_o[0]),
    .busy(busy_o[0]), .sd_addr(sdaddr_o[0]), .sd_din(sddin_o[0]), .sd_we(sdwe_o[0]),
    .sd_oe(sdoe_o[0]), .sd_dout(sd_dout));

  sdram_port_arbiter #(.NPORTS(N), .AW(AW), .DW(DW), .RR_MODE(1), .SLOT_CYCLES(S)) d_rr (
    .clk_i(clk_i), .res_n_i(res_n_i), .slot_start(slot_start), .req(req), .we(we), .lock(lock),
    .addr(addr), .din(din), .ack(ack_o[1]), .dout(dout_o[1]), .grant_idx(gidx_o[1]),
    .busy(busy_o[1]), .sd_addr(sdaddr_o[1]), .sd_din(sddin_o[1]), .sd_we(sdwe_o[1]),
    .sd_oe(sdoe_o[1]), .sd_dout(sd_dout));

  // Model: each access is described by the cycle it was granted in; outputs follow from its age.
  int            cyc = 0;
  bit            m_act [2];
  int            m_gt [2];
  int            m_gp [2];
  int            m_lo [2];
  int            m_ptr [2];
  logic          m_gwe [2];
  logic [AW-1:0] m_ga [2];
  logic [DW-1:0] m_gd [2];
  logic [DW-1:0] m_dout [2];
  int            glog [2][$];

  task automatic chk(input string name, input int m, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h at cycle %0d", name, m, got, exp, cyc);
    end
  endtask

  function automatic int pick(input int m);
    if (m_lo[m] >= 0 && req[m_lo[m]]) return m_lo[m];
    for (int i = 0; i < N; i++) begin
      int p;
      p = (m == 1) ? (m_ptr[m] + i) % N : i;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 1'b0; m_gt[m] = 0; m_gp[m] = 0; m_lo[m] = -1; m_ptr[m] = 0;
      m_gwe[m] = 1'b0; m_ga[m] = '0; m_gd[m] = '0; m_dout[m] = '0;
    end
  endtask

  always @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_act[m] && cyc - m_gt[m] == S) begin
          if (!m_gwe[m]) m_dout[m] = sd_dout;
          m_lo[m]  = lock[m_gp[m]] ? m_gp[m] : -1;
          m_ptr[m] = (m_gp[m] + 1) % N;
        end else if ((!m_act[m] || cyc - m_gt[m] >= S + 2) && slot_start && (|req)) begin
          int w;
          w = pick(m);
          m_act[m] = 1'b1; m_gt[m] = cyc; m_gp[m] = w;
          m_gwe[m] = we[w]; m_ga[m] = addr[w*AW +: AW]; m_gd[m] = din[w*DW +: DW];
        end
      end
      cyc++;
    end
  end

  always @(negedge clk_i) begin
    if (res_n_i) begin
      for (int m = 0; m < 2; m++) begin
        int  k;
        bit  acc;
        k   = cyc - m_gt[m];
        acc = m_act[m] && k >= 1 && k <= S;
        chk("busy", m, busy_o[m], m_act[m] && k >= 1 && k <= S + 1);
        chk("ack", m, ack_o[m], (m_act[m] && k == S + 1) ? (64'd1 << m_gp[m]) : 64'd0);
        chk("sd_we", m, sdwe_o[m], acc && m_gwe[m]);
        chk("sd_oe", m, sdoe_o[m], acc && !m_gwe[m]);
        chk("sd_addr", m, sdaddr_o[m], m_ga[m]);
        chk("sd_din", m, sddin_o[m], m_gd[m]);
        chk("grant_idx", m, gidx_o[m], m_gp[m]);
        chk("dout", m, dout_o[m], m_dout[m]);
        for (int p = 0; p < N; p++) if (ack_o[m][p]) glog[m].push_back(p);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Pulses slot_start, waits for the fixed instance's ack; optionally drops lock mid-access.
  task automatic slot_wait(output int lat, output logic [N-1:0] a, input int drop_lock_at);
    slot_start = 1'b1;
    tick(1);
    slot_start = 1'b0;
    lat = 1;
    while (ack_o[0] == '0 && lat < 30) begin
      if (lat == drop_lock_at) lock = '0;
      tick(1);
      lat++;
    end
    a = ack_o[0];
    if (lat >= 30) begin
      checks++; failures++;
      $display("FAIL ack_timeout got=none exp=ack within 30 cycles");
    end
    tick(1);
  endtask

  task automatic chk_log(input int m, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk("log_len", m, glog[m].size(), 4);
    for (int i = 0; i < 4 && i < glog[m].size(); i++) chk("log_grant", m, glog[m][i], e[i]);
  endtask

  initial begin
    int lat;
    int na;
    logic [N-1:0] a;
    model_reset();
    addr = {25'h0002222, 25'h0001111, 25'h0000abc};
    din  = {8'h22, 8'h11, 8'h3c};

    tick(2);
    for (int m = 0; m < 2; m++) begin
      chk("rst_busy", m, busy_o[m], 0);
      chk("rst_ack", m, ack_o[m], 0);
      chk("rst_sd_addr", m, sdaddr_o[m], 0);
      chk("rst_dout", m, dout_o[m], 0);
    end
    res_n_i = 1'b1;
    tick(2);

    // Fixed priority with two requesters: port 1, ack 9 cycles after the slot.
    req = 3'b110;
    slot_wait(lat, a, 0);
    chk("latency", 0, lat, 9);
    chk("ack_p1", 0, a, 3'b010);
    chk("sd_addr_p1", 0, sdaddr_o[0], 25'h0001111);
    req = '0;
    tick(2);

    // Port 2 read captures A5, then a port 0 write leaves dout alone.
    req = 3'b100; sd_dout = 8'ha5;
    slot_wait(lat, a, 0);
    chk("ack_p2", 0, a, 3'b100);
    chk("dout_read", 0, dout_o[0], 8'ha5);
    chk("dout_read", 1, dout_o[1], 8'ha5);
    req = 3'b001; we = 3'b001; sd_dout = 8'h5a;
    slot_wait(lat, a, 0);
    chk("dout_after_wr", 0, dout_o[0], 8'ha5);
    req = '0; we = '0;
    tick(2);

    // Reset three cycles into an access to port 1.
    req = 3'b110;
    slot_start = 1'b1; tick(1); slot_start = 1'b0;
    tick(3);
    #2 res_n_i = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("arst_busy", m, busy_o[m], 0);
      chk("arst_sd_we", m, sdwe_o[m], 0);
      chk("arst_sd_oe", m, sdoe_o[m], 0);
      chk("arst_grant", m, gidx_o[m], 0);
    end
    @(posedge clk_i); #1 res_n_i = 1'b1;
    na = 0;
    repeat (12) begin
      tick(1);
      if (ack_o[0] != '0 || ack_o[1] != '0) na++;
    end
    chk("no_ack_after_rst", 0, na, 0);

    // All three requesting over four slots.
    req = 3'b111;
    glog[0].delete(); glog[1].delete();
    repeat (4) slot_wait(lat, a, 0);
    chk_log(0, 0, 0, 0, 0);
    chk_log(1, 0, 1, 2, 0);
    req = '0;
    tick(2);

    // Port 2 lock held for three slots, released during the third access.
    glog[0].delete(); glog[1].delete();
    lock = 3'b100; req = 3'b100;
    slot_wait(lat, a, 0);
    req = 3'b101;
    slot_wait(lat, a, 0);
    slot_wait(lat, a, 4);
    slot_wait(lat, a, 0);
    chk_log(0, 2, 2, 2, 0);
    chk_log(1, 2, 2, 2, 0);
    req = '0; lock = '0;
    tick(2);

    // Slot coinciding with the ack is missed; mid-access address change is not seen.
    req = 3'b001;
    slot_start = 1'b1; tick(1); slot_start = 1'b0;
    tick(2);
    addr[0 +: AW] = 25'h0000def;
    tick(2);
    chk("sd_addr_stable", 0, sdaddr_o[0], 25'h0000abc);
    tick(4);
    slot_start = 1'b1;
    chk("ack_at_slot", 0, ack_o[0], 3'b001);
    tick(1);
    slot_start = 1'b0;
    chk("missed_slot_busy", 0, busy_o[0], 0);
    chk("missed_slot_busy", 1, busy_o[1], 0);
    slot_wait(lat, a, 0);
    chk("latency_retry", 0, lat, 9);
    chk("sd_addr_new", 0, sdaddr_o[0], 25'h0000def);
    req = '0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
